uart_rx_deframer: RTL and testbench
===================================

Name: uart_rx_deframer

Overview:
- Serial receive front end for the UART path. It converts the asynchronous rx line into bytes for the UART controller and its rx_output consumer.
- Synchronises the line, validates the start bit, samples 8N1 data LSB-first at mid-bit, checks the stop bit, and presents each byte through a one-deep valid/ready holding register.
- Runs on the 100 MHz system clock.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200). Must be >= 4.
- SYNC_STAGES, 2, flops in the rx input synchroniser. Must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_serial  input  1  asynchronous UART line; idles high.
- rx_data  output  8  received byte; held stable while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready.
- frame_err  output  1  one-cycle pulse when a bad stop bit is detected.
- overrun_err  output  1  one-cycle pulse when a byte is dropped because the holding register is full.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset (already decided): single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - Synchroniser flops = 1.
  - rx_data = 8'h00.
  - rx_valid, frame_err, overrun_err, busy = 0.
  - FSM = IDLE; bit counter and clock counter = 0.
- Reset asserted mid-frame aborts the frame immediately. No partial byte is delivered.
- Synchroniser: rx_s is the last stage of SYNC_STAGES flops. All FSM decisions use rx_s only.
- Timing definitions:
  - H = CLKS_PER_BIT/2 (integer division).
  - t0 = first clock edge on which the FSM in IDLE sees rx_s = 0.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rx_s = 0 -> START; clock counter cleared.
- START:
  - At t0+H, sample rx_s.
  - rx_s = 1 -> IDLE (glitch rejected; no error).
  - rx_s = 0 -> DATA; clock counter and bit index cleared.
- DATA:
  - Bit k (k = 0..7) is sampled at t0 + H + (k+1)*CLKS_PER_BIT and shifted in LSB-first.
  - After bit 7 -> STOP.
- STOP:
  - Stop bit is sampled at t0 + H + 9*CLKS_PER_BIT.
  - rx_s = 1 -> delivery (below), then IDLE. The next start bit may be detected on the very next cycle.
  - rx_s = 0 -> frame_err pulses for 1 cycle, byte discarded, go to BREAK.
- BREAK:
  - Wait until rx_s = 1, then go to IDLE.
  - A line held low (break) produces exactly one frame_err.
- Delivery, on the cycle after the stop sample:
  - If rx_valid = 0, or rx_valid & rx_ready in that same cycle: load rx_data and set rx_valid = 1.
  - A simultaneous accept and load keeps rx_valid = 1 with the new data; no bubble.
  - Otherwise: overrun_err pulses for 1 cycle, the new byte is dropped, and the old rx_data/rx_valid are retained.
- rx_valid clears on the cycle after rx_valid & rx_ready, unless a new load occurs in that cycle.
- rx_data changes only on a load.
- frame_err and overrun_err never both pulse for the same frame.
- Counters:
  - Clock counter width is $clog2(CLKS_PER_BIT); it wraps to 0 at each sample point.
  - Bit index is 3 bits.
- No parity support. No baud auto-detect.

Test Plan:
(All scenarios use CLKS_PER_BIT=16, SYNC_STAGES=2, and rx_ready=1 unless stated.)
1. Send 0xA5 with a good stop bit -> rx_valid rises at t0+H+9*16+1 with rx_data=8'hA5; frame_err=0; busy low after the stop sample.
2. Drive rx_serial low for 4 cycles, then high -> FSM returns to IDLE at t0+8; no rx_valid, no frame_err.
3. Send 0x3C with stop bit = 0, line held low for 40 cycles -> exactly one frame_err pulse; rx_valid stays 0; FSM stays in BREAK until the line goes high; a following 0x5A is received correctly.
4. Hold rx_ready=0 and send 0x11 then 0x22 -> rx_data=8'h11 with rx_valid=1; one overrun_err pulse at the second delivery; after raising rx_ready, 0x11 is consumed and rx_valid=0.
5. Send back-to-back frames 0x00 and 0xFF with zero idle between them, and assert rx_ready in the same cycle as the second load -> both bytes delivered in order; rx_valid never drops between them when accept and load coincide.
6. Assert rst_n=0 during data bit 3 of 0x96, then release and send 0x69 -> no output from the aborted frame; all outputs at reset values; 0x69 is then received correctly.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - 8N1 UART receive deframer with a one-deep valid/ready holding register
module uart_rx_deframer #(
   parameter int CLKS_PER_BIT = 868,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_serial,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun_err,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2:0]             bit_q, bit_d;
   logic [7:0]             shift_q, shift_d;
   logic                   deliver_q, deliver_d;
   logic                   ferr_d;

   assign rx_s = sync_q[SYNC_STAGES-1];
   assign busy = (state_q != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         deliver_q <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_serial};
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         deliver_q <= deliver_d;
         frame_err <= ferr_d;
      end
   end

   // Counter counts cycles since the last sample point; each state samples when it hits its limit.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CW'(1);
      bit_d     = bit_q;
      shift_d   = shift_q;
      deliver_d = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               bit_d = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  deliver_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Holding register: a load may coincide with an accept, so a full register only overruns without ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data     <= 8'h00;
         rx_valid    <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         overrun_err <= 1'b0;
         if (deliver_q) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shift_q;
               rx_valid <= 1'b1;
            end else begin
               overrun_err <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - scoreboard bench for uart_rx_deframer at 16 clocks per bit
module tb_uart_rx_deframer;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_serial = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b1;
   logic       frame_err;
   logic       overrun_err;
   logic       busy;

   int checks = 0;
   int failures = 0;
   int ferr_seen = 0;
   int ovr_seen = 0;
   logic [7:0] exp_q[$];

   uart_rx_deframer #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .rx_serial(rx_serial), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
      .overrun_err(overrun_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake and counts error pulses.
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_err) ferr_seen++;
         if (overrun_err) ovr_seen++;
         if (rx_valid && rx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_byte actual=%0h expected=none", rx_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (rx_data !== e) begin
                  failures++;
                  $display("FAIL rx_byte actual=%0h expected=%0h", rx_data, e);
               end
            end
         end
      end
   end

   // Called just after a rising edge; drives one full 10-bit frame.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_serial = frame[i];
         repeat (CPB) @(posedge clk);
         #2;
      end
   endtask

   task automatic align();
      @(posedge clk);
      #2;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2;
      @(negedge clk);
      chk("reset_valid", {31'd0, rx_valid}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_data", {24'd0, rx_data}, 32'd0);
      chk("reset_errs", {30'd0, frame_err, overrun_err}, 32'd0);
      rst_n = 1'b1;
      repeat (4) align();

      // 1: good frame, delivery timing
      align();
      exp_q.push_back(8'hA5);
      fork
         send_byte(8'hA5, 1'b1);
         begin
            repeat (155) @(posedge clk);
            @(negedge clk);
            chk("t1_valid_before", {31'd0, rx_valid}, 32'd0);
            chk("t1_busy_after_stop", {31'd0, busy}, 32'd0);
            @(negedge clk);
            chk("t1_valid_rise", {31'd0, rx_valid}, 32'd1);
            chk("t1_data", {24'd0, rx_data}, 32'hA5);
         end
      join
      repeat (10) align();
      chk("t1_no_ferr", ferr_seen, 0);

      // 2: glitch rejected at mid start bit
      align();
      fork
         begin
            rx_serial = 1'b0;
            repeat (4) @(posedge clk);
            #2 rx_serial = 1'b1;
         end
         begin
            repeat (10) @(posedge clk);
            @(negedge clk);
            chk("t2_busy_start", {31'd0, busy}, 32'd1);
            @(negedge clk);
            chk("t2_idle_at_t0_h", {31'd0, busy}, 32'd0);
         end
      join
      repeat (20) align();
      chk("t2_no_ferr", ferr_seen, 0);
      chk("t2_no_valid", {31'd0, rx_valid}, 32'd0);

      // 3: bad stop bit then break, then recovery
      align();
      send_byte(8'h3C, 1'b0);
      repeat (40) align();
      chk("t3_one_ferr", ferr_seen, 1);
      chk("t3_busy_break", {31'd0, busy}, 32'd1);
      chk("t3_no_valid", {31'd0, rx_valid}, 32'd0);
      rx_serial = 1'b1;
      repeat (5) align();
      chk("t3_idle_after_break", {31'd0, busy}, 32'd0);
      exp_q.push_back(8'h5A);
      send_byte(8'h5A, 1'b1);
      repeat (10) align();
      chk("t3_ferr_total", ferr_seen, 1);

      // 4: overrun while the consumer stalls
      rx_ready = 1'b0;
      exp_q.push_back(8'h11);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      repeat (10) align();
      chk("t4_valid_held", {31'd0, rx_valid}, 32'd1);
      chk("t4_data_held", {24'd0, rx_data}, 32'h11);
      chk("t4_one_overrun", ovr_seen, 1);
      rx_ready = 1'b1;
      repeat (3) align();
      chk("t4_drained", {31'd0, rx_valid}, 32'd0);
      chk("t4_no_ferr", ferr_seen, 1);

      // 5: back-to-back frames, accept coincides with second load
      rx_ready = 1'b0;
      align();
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      fork
         begin
            send_byte(8'h00, 1'b1);
            send_byte(8'hFF, 1'b1);
         end
         begin
            repeat (315) @(posedge clk);
            #2 rx_ready = 1'b1;
            @(negedge clk);
            chk("t5_first_valid", {31'd0, rx_valid}, 32'd1);
            @(negedge clk);
            chk("t5_no_bubble", {31'd0, rx_valid}, 32'd1);
            chk("t5_second_data", {24'd0, rx_data}, 32'hFF);
         end
      join
      repeat (10) align();
      chk("t5_no_overrun", ovr_seen, 1);

      // 6: reset during data bit 3 aborts the frame
      align();
      fork
         send_byte(8'h96, 1'b1);
         begin
            repeat (72) @(posedge clk);
            #2 rst_n = 1'b0;
            @(negedge clk);
            chk("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
            chk("t6_rst_busy", {31'd0, busy}, 32'd0);
            chk("t6_rst_data", {24'd0, rx_data}, 32'd0);
         end
      join
      repeat (5) align();
      rst_n = 1'b1;
      repeat (5) align();
      chk("t6_no_partial", {31'd0, rx_valid}, 32'd0);
      exp_q.push_back(8'h69);
      send_byte(8'h69, 1'b1);
      repeat (20) align();

      chk("sb_empty", exp_q.size(), 0);
      chk("final_ferr", ferr_seen, 1);
      chk("final_overrun", ovr_seen, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
